// File: rtl/dma_prio_arbiter.sv
// DMA channel arbiter: qualifies DREQ/SW requests, picks a winner (fixed or rotating priority), runs the HRQ/HLDA handshake.
// Latency: DREQ->pend 1, pend->HRQ 1, HLDA->DACK 1, svc_done->release 1. Holds in REQ until HLDA; a grant is frozen until svc_done or loss of HLDA.
module dma_prio_arbiter #(
    parameter int NUM_CH = 4,
    localparam int CW = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic [NUM_CH-1:0] MASK,
    input  logic [NUM_CH-1:0] SW_REQ,
    input  logic              DREQ_ACT_LOW,
    input  logic              DACK_ACT_HIGH,
    input  logic              ROT_PRI,
    input  logic              CTRL_DIS,
    input  logic              HLDA,
    input  logic              svc_done,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic              grant_vld,
    output logic [CW-1:0]     grant_ch,
    output logic [NUM_CH-1:0] pend
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              hrq_q, hrq_d;
    logic [NUM_CH-1:0] dack_q, dack_d;
    logic              grant_vld_q, grant_vld_d;
    logic [CW-1:0]     grant_ch_q, grant_ch_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [CW-1:0]     top_q, top_d;

    logic [CW-1:0]     win_ch;
    logic [CW-1:0]     idx;
    logic              found;
    int                s;

    // Scan from the priority pointer (or ch0 in fixed mode), wrapping explicitly at NUM_CH.
    always_comb begin
        win_ch = '0;
        found  = 1'b0;
        idx    = '0;
        s      = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            s = ROT_PRI ? (int'(top_q) + i) : i;
            if (s >= NUM_CH) begin
                s = s - NUM_CH;
            end
            idx = s[CW-1:0];
            if (!found && pend_q[idx]) begin
                found  = 1'b1;
                win_ch = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        hrq_d       = hrq_q;
        dack_d      = dack_q;
        grant_vld_d = grant_vld_q;
        grant_ch_d  = grant_ch_q;
        top_d       = top_q;
        pend_d      = ((DREQ ^ {NUM_CH{DREQ_ACT_LOW}}) & ~MASK) | SW_REQ;

        case (state_q)
            IDLE: begin
                hrq_d = 1'b0;
                if ((|pend_q) && !CTRL_DIS) begin
                    state_d = REQ;
                    hrq_d   = 1'b1;
                end
            end
            REQ: begin
                if (HLDA && (|pend_q)) begin
                    state_d     = GRANT;
                    grant_ch_d  = win_ch;
                    grant_vld_d = 1'b1;
                    dack_d      = {{(NUM_CH-1){1'b0}}, 1'b1} << win_ch;
                end else if (pend_q == '0) begin
                    state_d = IDLE;
                    hrq_d   = 1'b0;
                end
            end
            GRANT: begin
                // Completion wins over a simultaneous loss of HLDA, so it still rotates.
                if (svc_done) begin
                    state_d     = RELEASE;
                    hrq_d       = 1'b0;
                    dack_d      = '0;
                    grant_vld_d = 1'b0;
                    if (ROT_PRI) begin
                        top_d = (grant_ch_q == CW'(NUM_CH - 1)) ? '0 : grant_ch_q + CW'(1);
                    end
                end else if (!HLDA) begin
                    state_d     = IDLE;
                    hrq_d       = 1'b0;
                    dack_d      = '0;
                    grant_vld_d = 1'b0;
                end
            end
            RELEASE: begin
                state_d = IDLE;
                hrq_d   = 1'b0;
            end
            default: begin
                state_d     = IDLE;
                hrq_d       = 1'b0;
                dack_d      = '0;
                grant_vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            hrq_q       <= 1'b0;
            dack_q      <= '0;
            grant_vld_q <= 1'b0;
            grant_ch_q  <= '0;
            pend_q      <= '0;
            top_q       <= '0;
        end else begin
            state_q     <= state_d;
            hrq_q       <= hrq_d;
            dack_q      <= dack_d;
            grant_vld_q <= grant_vld_d;
            grant_ch_q  <= grant_ch_d;
            pend_q      <= pend_d;
            top_q       <= top_d;
        end
    end

    // DACK state is kept active-high internally; the pin polarity follows the command bit live.
    assign DACK      = DACK_ACT_HIGH ? dack_q : ~dack_q;
    assign HRQ       = hrq_q;
    assign grant_vld = grant_vld_q;
    assign grant_ch  = grant_ch_q;
    assign pend      = pend_q;

endmodule

// File: tb/tb_dma_prio_arbiter.sv
// Directed bench for dma_prio_arbiter: a 4-channel instance plus a 3-channel instance for the wrap check.
module tb_dma_prio_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] DREQ, MASK, SW_REQ;
    logic       DREQ_ACT_LOW, DACK_ACT_HIGH, ROT_PRI, CTRL_DIS, HLDA, svc_done;
    logic       HRQ, grant_vld;
    logic [3:0] DACK, pend;
    logic [1:0] grant_ch;

    logic [2:0] DREQ3, MASK3, SW3;
    logic       HRQ3, grant_vld3;
    logic [2:0] DACK3, pend3;
    logic [1:0] grant_ch3;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    dma_prio_arbiter #(.NUM_CH(4)) dut (
        .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .MASK(MASK), .SW_REQ(SW_REQ),
        .DREQ_ACT_LOW(DREQ_ACT_LOW), .DACK_ACT_HIGH(DACK_ACT_HIGH), .ROT_PRI(ROT_PRI),
        .CTRL_DIS(CTRL_DIS), .HLDA(HLDA), .svc_done(svc_done), .HRQ(HRQ), .DACK(DACK),
        .grant_vld(grant_vld), .grant_ch(grant_ch), .pend(pend)
    );

    dma_prio_arbiter #(.NUM_CH(3)) dut3 (
        .CLK(CLK), .RESET(RESET), .DREQ(DREQ3), .MASK(MASK3), .SW_REQ(SW3),
        .DREQ_ACT_LOW(DREQ_ACT_LOW), .DACK_ACT_HIGH(DACK_ACT_HIGH), .ROT_PRI(ROT_PRI),
        .CTRL_DIS(CTRL_DIS), .HLDA(HLDA), .svc_done(svc_done), .HRQ(HRQ3), .DACK(DACK3),
        .grant_vld(grant_vld3), .grant_ch(grant_ch3), .pend(pend3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_grant();
        int n = 0;
        while (!grant_vld && n < 20) begin
            tick(1);
            n++;
        end
    endtask

    task automatic serve(input string tag, input int exp_ch);
        wait_grant();
        chk({tag, "_vld"}, grant_vld, 1);
        chk(tag, grant_ch, exp_ch);
        svc_done = 1'b1;
        tick(1);
        svc_done = 1'b0;
        chk({tag, "_rel"}, {HRQ, grant_vld}, 0);
    endtask

    task automatic serve3(input string tag, input int exp_ch);
        int n = 0;
        while (!grant_vld3 && n < 20) begin
            tick(1);
            n++;
        end
        chk({tag, "_vld"}, grant_vld3, 1);
        chk(tag, grant_ch3, exp_ch);
        svc_done = 1'b1;
        tick(1);
        svc_done = 1'b0;
        chk({tag, "_rel"}, {HRQ3, grant_vld3}, 0);
    endtask

    initial begin
        RESET = 1'b1; DREQ = '0; MASK = '0; SW_REQ = '0;
        DREQ_ACT_LOW = 1'b0; DACK_ACT_HIGH = 1'b0; ROT_PRI = 1'b0; CTRL_DIS = 1'b0;
        HLDA = 1'b0; svc_done = 1'b0; DREQ3 = '0; MASK3 = '0; SW3 = '0;
        tick(2);
        chk("rst_dack", DACK, 4'hF);
        chk("rst_hrq", HRQ, 0);
        chk("rst_vld", grant_vld, 0);
        chk("rst_ch", grant_ch, 0);
        chk("rst_pend", pend, 0);
        RESET = 1'b0;

        // Basic latency: DREQ[2] with HLDA tied high
        HLDA = 1'b1;
        DREQ = 4'b0100;
        tick(1);
        chk("lat_pend", pend, 4'b0100);
        chk("lat_hrq1", HRQ, 0);
        tick(1);
        chk("lat_hrq2", HRQ, 1);
        chk("lat_dack2", DACK, 4'hF);
        tick(1);
        chk("lat_dack3", DACK, 4'b1011);
        chk("lat_ch3", grant_ch, 2);
        chk("lat_vld3", grant_vld, 1);
        svc_done = 1'b1;
        DREQ = '0;
        tick(1);
        svc_done = 1'b0;
        chk("done_dack", DACK, 4'hF);
        chk("done_hrq", HRQ, 0);
        chk("done_vld", grant_vld, 0);
        tick(3);

        // Fixed priority: ch1 beats ch3 every time
        DREQ = 4'b1010;
        serve("fix1", 1);
        serve("fix2", 1);
        DREQ = '0;
        tick(3);

        // Rotating priority
        ROT_PRI = 1'b1;
        DREQ = 4'hF;
        serve("rot0", 0);
        serve("rot1", 1);
        serve("rot2", 2);
        serve("rot3", 3);
        serve("rot4", 0);
        serve("rot5", 1);
        // Hold lost on ch2: no rotation, ch2 wins again
        wait_grant();
        chk("hl_ch", grant_ch, 2);
        HLDA = 1'b0;
        tick(1);
        chk("hl_dack", DACK, 4'hF);
        chk("hl_hrq", HRQ, 0);
        chk("hl_vld", grant_vld, 0);
        HLDA = 1'b1;
        serve("hl_again", 2);
        DREQ = '0;
        ROT_PRI = 1'b0;
        tick(3);

        // Masking and software requests
        MASK = 4'b0001;
        DREQ = 4'b0001;
        tick(4);
        chk("mask_hrq", HRQ, 0);
        chk("mask_pend", pend, 0);
        SW_REQ = 4'b0001;
        serve("sw", 0);
        SW_REQ = '0; DREQ = '0; MASK = '0;
        tick(3);

        // Active-low DREQ, then withdrawal in REQ
        HLDA = 1'b0;
        DREQ_ACT_LOW = 1'b1;
        DREQ = 4'b1110;
        tick(1);
        chk("al_pend", pend, 4'b0001);
        tick(1);
        chk("al_hrq", HRQ, 1);
        DREQ = 4'b1111;
        tick(1);
        chk("wd_pend", pend, 0);
        chk("wd_hrq_hold", HRQ, 1);
        tick(1);
        chk("wd_hrq", HRQ, 0);
        chk("wd_dack", DACK, 4'hF);
        chk("wd_vld", grant_vld, 0);
        DREQ_ACT_LOW = 1'b0;
        DREQ = '0;
        tick(2);

        // Controller disable blocks IDLE -> REQ
        HLDA = 1'b1;
        CTRL_DIS = 1'b1;
        DREQ = 4'b0001;
        tick(4);
        chk("dis_hrq", HRQ, 0);
        chk("dis_pend", pend, 4'b0001);
        CTRL_DIS = 1'b0;
        serve("dis_off", 0);
        DREQ = '0;
        tick(3);

        // DACK polarity follows the command bit live
        DACK_ACT_HIGH = 1'b1;
        #1;
        chk("pol_idle", DACK, 4'h0);

        // Reset in GRANT, then pointer back at ch0
        DREQ = 4'b0010;
        wait_grant();
        chk("rg_dack", DACK, 4'b0010);
        RESET = 1'b1;
        tick(1);
        chk("rg_hrq", HRQ, 0);
        chk("rg_dack_rst", DACK, 4'h0);
        chk("rg_vld", grant_vld, 0);
        chk("rg_ch", grant_ch, 0);
        chk("rg_pend", pend, 0);
        RESET = 1'b0;
        ROT_PRI = 1'b1;
        DREQ = 4'hF;
        serve("rst_top", 0);
        DREQ = '0;
        tick(3);

        // Three-channel wrap
        DREQ3 = 3'b111;
        serve3("w3_0", 0);
        serve3("w3_1", 1);
        serve3("w3_2", 2);
        serve3("w3_3", 0);
        DREQ3 = '0;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
